subr_stack_ctrl: RTL and testbench
==================================

SUBR_STACK_CTRL -- requirements
Module: subr_stack_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of return-address entries (power of two, 2..16).
REQ-002 The block SHALL have parameter AW, default 10, giving the program-counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port opcode, input, 6 bits: current instruction opcode, the same field the control unit decodes.
REQ-006 The block SHALL have port pc_plus1, input, AW bits: address of the instruction following the current one.
REQ-007 The block SHALL have port ret_addr, output, AW bits: popped return address for the PC mux.
REQ-008 The block SHALL have port s_ret, output, 1 bit: selects ret_addr into the PC.
REQ-009 The block SHALL have port stall, output, 1 bit: freezes the PC and the register-file write.
REQ-010 The block SHALL have port depth, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-011 The block SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-012 JAL SHALL be opcode 6'b100111 and RET SHALL be opcode 6'b101000; all other opcodes SHALL leave state unchanged.
REQ-013 The FSM SHALL have three states, IDLE, RET_WAIT and HALT, and SHALL leave reset in IDLE.
REQ-014 In IDLE, a JAL with depth<DEPTH SHALL write pc_plus1 at the stack pointer sp and increment sp and depth at the same edge, with no stall.
REQ-015 In IDLE, a RET with depth>0 SHALL assert stall combinationally in that cycle, decrement sp and depth, register entry[sp-1] into ret_addr, and go to RET_WAIT.
REQ-016 In RET_WAIT, the block SHALL drive s_ret=1 and stall=0 for exactly one cycle, ignore opcode, and return to IDLE; total RET latency is 2 cycles.
REQ-017 A RET with depth==0 SHALL set underflow, assert stall, and go to HALT.
REQ-018 A JAL with depth==DEPTH SHALL set overflow, assert stall, and go to HALT (unless REQ-024 applies).
REQ-019 In HALT, stall SHALL be held at 1, s_ret held at 0, and all opcodes ignored until reset.
REQ-020 sp SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; depth SHALL never exceed DEPTH.
REQ-021 s_ret SHALL be 0 in IDLE and HALT; ret_addr SHALL hold its last popped value outside RET_WAIT.

Reset
REQ-022 Asserting reset, in any state and including mid-RET, SHALL immediately force state=IDLE, sp=0, depth=0, ret_addr=0, s_ret=0, stall=0, overflow=0 and underflow=0.
REQ-023 Stack entry contents SHALL NOT require reset; after reset the stack is empty by depth=0.

Configuration
REQ-024 With SUBR_STACK_WRAP_EN defined, a JAL at depth==DEPTH SHALL overwrite the oldest entry, advance sp, keep depth=DEPTH, leave overflow at 0, and stay in IDLE; without the macro, REQ-018 applies.

Structure
REQ-025 Package uc_pkg SHALL hold the JAL/RET opcode constants and the FSM state typedef, and the existing control unit SHALL share these constants.
REQ-026 Storage SHALL be a sub-module lifo_regs (DEPTH x AW, one write port, one registered read port); the FSM, sp and flags SHALL stay in subr_stack_ctrl.

Verification
REQ-027 Reset, then JAL with pc_plus1=0x010 and RET -> depth goes 1 then 0, stall=1 in the RET cycle, next cycle s_ret=1 and ret_addr=0x010.
REQ-028 Nested JALs with pc_plus1=0x005, 0x020, 0x3FF, then three RETs -> ret_addr sequence 0x3FF, 0x020, 0x005, and depth returns to 0.
REQ-029 RET on empty -> underflow=1 and stall=1 held for 10 further cycles despite JAL/RET opcodes; reset clears both.
REQ-030 9 JALs with DEPTH=8, without the macro -> overflow=1 at the 9th and state HALT; with SUBR_STACK_WRAP_EN -> no overflow, and 8 RETs return the last 8 addresses, newest first.
REQ-031 Assert reset during RET_WAIT -> s_ret=0, ret_addr=0 and depth=0 before the next edge; a subsequent RET gives underflow.
REQ-032 Arithmetic opcode 6'b001100 and jump opcode 6'b100110 issued between JAL and RET -> depth and ret_addr unchanged and stall=0.

Source files
------------

// File: rtl/subr_stack_ctrl_pkg.sv
// Shared control-unit constants: subroutine opcodes and the return-stack FSM state type.
package uc_pkg;

  localparam logic [5:0] OP_JAL = 6'b100111;
  localparam logic [5:0] OP_RET = 6'b101000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RET_WAIT = 2'd1,
    HALT     = 2'd2
  } subr_state_t;

endpackage

// File: rtl/subr_stack_ctrl_if.sv
// Opcode/PC inputs and return-address/stall outputs exchanged between the control unit and the return stack.
interface subr_stack_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 10
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic [5:0]    opcode;
  logic [AW-1:0] pc_plus1;
  logic [AW-1:0] ret_addr;
  logic          s_ret;
  logic          stall;
  logic [DW-1:0] depth;
  logic          overflow;
  logic          underflow;

  modport master (
    output opcode, pc_plus1,
    input  ret_addr, s_ret, stall, depth, overflow, underflow
  );

  modport slave (
    input  opcode, pc_plus1,
    output ret_addr, s_ret, stall, depth, overflow, underflow
  );
endinterface

// File: rtl/subr_stack_ctrl_lifo.sv
// Return-address storage: DEPTH x AW register file, one write port, one registered read port.
module lifo_regs #(
  parameter int DEPTH = 8,
  parameter int AW    = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [AW-1:0]            i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [AW-1:0]            o_rdata
);

  logic [AW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rdata;

  // Entries need no reset; emptiness is tracked by the controller's depth count.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/subr_stack_ctrl.sv
// Hardware return-address stack for JAL/RET with stall/s_ret handshake to the PC mux.
// Optional macro SUBR_STACK_WRAP_EN: a JAL on a full stack overwrites the oldest entry instead of halting.
module subr_stack_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  subr_stack_ctrl_if.slave  bus
);
  import uc_pkg::*;

  localparam int SPW = $clog2(DEPTH);
  localparam int DW  = SPW + 1;

  subr_state_t    r_state, w_next;
  logic [SPW-1:0] r_sp;
  logic [DW-1:0]  r_depth;
  logic           r_overflow, r_underflow;
  logic           w_full, w_empty;
  logic           w_push, w_pop, w_setOvf, w_setUnf, w_stall, w_sRet;

  assign w_full  = (r_depth == DW'(DEPTH));
  assign w_empty = (r_depth == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // A RET stalls in its own cycle while the popped address is registered, then s_ret steers it in.
  always_comb begin
    w_next   = r_state;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_setOvf = 1'b0;
    w_setUnf = 1'b0;
    w_stall  = 1'b0;
    w_sRet   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.opcode == OP_JAL) begin
          if (!w_full) begin
            w_push = 1'b1;
          end else begin
`ifdef SUBR_STACK_WRAP_EN
            w_push = 1'b1;
`else
            w_setOvf = 1'b1;
            w_stall  = 1'b1;
            w_next   = HALT;
`endif
          end
        end else if (bus.opcode == OP_RET) begin
          w_stall = 1'b1;
          if (w_empty) begin
            w_setUnf = 1'b1;
            w_next   = HALT;
          end else begin
            w_pop  = 1'b1;
            w_next = RET_WAIT;
          end
        end
      end
      RET_WAIT: begin
        w_sRet = 1'b1;
        w_next = IDLE;
      end
      HALT: begin
        w_stall = 1'b1;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Depth saturates at DEPTH on a wrapping push while sp keeps advancing over the oldest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp        <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_sp <= r_sp + SPW'(1);
        if (!w_full) r_depth <= r_depth + DW'(1);
      end else if (w_pop) begin
        r_sp    <= r_sp - SPW'(1);
        r_depth <= r_depth - DW'(1);
      end
      if (w_setOvf) r_overflow  <= 1'b1;
      if (w_setUnf) r_underflow <= 1'b1;
    end
  end

  lifo_regs #(.DEPTH(DEPTH), .AW(AW)) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_push),
    .i_waddr (r_sp),
    .i_wdata (bus.pc_plus1),
    .i_re    (w_pop),
    .i_raddr (r_sp - SPW'(1)),
    .o_rdata (bus.ret_addr)
  );

  // Stall is decoded from the live opcode, so it is masked while reset is held.
  assign bus.stall     = w_stall & ~reset;
  assign bus.s_ret     = w_sRet;
  assign bus.depth     = r_depth;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_subr_stack_ctrl.sv
// Scoreboard bench for subr_stack_ctrl: expected return addresses are queued at each RET and
// checked by a monitor whenever s_ret is presented; flags/depth/stall are checked directly.
module tb_subr_stack_ctrl;
  import uc_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 10;
  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_ARITH = 6'b001100;
  localparam logic [5:0] OP_JUMP  = 6'b100110;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   nTests = 0;
  int   nFail  = 0;
  logic [AW-1:0] expQ [$];
  logic [AW-1:0] monExp;

  subr_stack_ctrl_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  subr_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read 1 time unit later.
  task automatic applyStimulus(input logic [5:0] op, input logic [AW-1:0] pc);
    @(negedge clk);
    bus.opcode   = op;
    bus.pc_plus1 = pc;
    #1;
  endtask

  task automatic resetDut();
    reset        = 1'b1;
    bus.opcode   = OP_NOP;
    bus.pc_plus1 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic doRet(input logic [AW-1:0] exp);
    applyStimulus(OP_RET, '0);
    checkOutput("ret_stall", 32'(bus.stall), 32'd1);
    expQ.push_back(exp);
    applyStimulus(OP_NOP, '0);
    checkOutput("retwait_sret", 32'(bus.s_ret), 32'd1);
  endtask

  // Monitor: whenever the DUT presents a return address, compare against the queue head.
  always @(negedge clk) begin
    if (!reset && bus.s_ret) begin
      if (expQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("[TB] FAIL sb_unexpected: got s_ret=1 ret_addr=0x%0h, want no return", bus.ret_addr);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("sb_ret_addr", 32'(bus.ret_addr), 32'(monExp));
        checkOutput("sb_stall", 32'(bus.stall), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.opcode   = OP_RET;
    bus.pc_plus1 = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_stall", 32'(bus.stall), 32'd0);
    checkOutput("rst_sret", 32'(bus.s_ret), 32'd0);
    checkOutput("rst_depth", 32'(bus.depth), 32'd0);
    checkOutput("rst_ret_addr", 32'(bus.ret_addr), 32'd0);
    checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("rst_unf", 32'(bus.underflow), 32'd0);
    bus.opcode = OP_NOP;
    reset      = 1'b0;

    // Single call/return
    applyStimulus(OP_JAL, 10'h010);
    checkOutput("jal_stall", 32'(bus.stall), 32'd0);
    applyStimulus(OP_RET, '0);
    checkOutput("jal_depth1", 32'(bus.depth), 32'd1);
    checkOutput("ret_stall", 32'(bus.stall), 32'd1);
    expQ.push_back(10'h010);
    applyStimulus(OP_NOP, '0);
    checkOutput("retwait_sret", 32'(bus.s_ret), 32'd1);
    checkOutput("ret_depth0", 32'(bus.depth), 32'd0);
    applyStimulus(OP_NOP, '0);
    checkOutput("idle_sret", 32'(bus.s_ret), 32'd0);
    checkOutput("hold_ret_addr", 32'(bus.ret_addr), 32'h010);

    // Unrelated opcodes between JAL and RET
    applyStimulus(OP_JAL, 10'h100);
    applyStimulus(OP_ARITH, 10'h001);
    checkOutput("arith_depth", 32'(bus.depth), 32'd1);
    checkOutput("arith_stall", 32'(bus.stall), 32'd0);
    applyStimulus(OP_JUMP, 10'h002);
    checkOutput("jump_depth", 32'(bus.depth), 32'd1);
    checkOutput("jump_stall", 32'(bus.stall), 32'd0);
    checkOutput("jump_ret_addr", 32'(bus.ret_addr), 32'h010);
    applyStimulus(OP_ARITH, 10'h003);
    checkOutput("arith2_depth", 32'(bus.depth), 32'd1);
    doRet(10'h100);

    // Nested calls
    applyStimulus(OP_JAL, 10'h005);
    applyStimulus(OP_JAL, 10'h020);
    applyStimulus(OP_JAL, 10'h3FF);
    applyStimulus(OP_NOP, '0);
    checkOutput("nest_depth3", 32'(bus.depth), 32'd3);
    doRet(10'h3FF);
    doRet(10'h020);
    doRet(10'h005);
    checkOutput("nest_depth0", 32'(bus.depth), 32'd0);

    // Underflow halts until reset
    resetDut();
    applyStimulus(OP_RET, '0);
    checkOutput("unf_stall", 32'(bus.stall), 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? OP_JAL : OP_RET, 10'(i));
      checkOutput("unf_hold_flag", 32'(bus.underflow), 32'd1);
      checkOutput("unf_hold_stall", 32'(bus.stall), 32'd1);
      checkOutput("unf_hold_depth", 32'(bus.depth), 32'd0);
    end
    resetDut();
    applyStimulus(OP_NOP, '0);
    checkOutput("unf_clear_flag", 32'(bus.underflow), 32'd0);
    checkOutput("unf_clear_stall", 32'(bus.stall), 32'd0);

    // Nine JALs on an eight-entry stack
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(OP_JAL, 10'(32'h100 + i));
      checkOutput("fill_stall", 32'(bus.stall), 32'd0);
    end
    applyStimulus(OP_JAL, 10'h108);
    checkOutput("full_depth", 32'(bus.depth), 32'd8);
`ifdef SUBR_STACK_WRAP_EN
    checkOutput("wrap_stall", 32'(bus.stall), 32'd0);
    applyStimulus(OP_NOP, '0);
    checkOutput("wrap_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("wrap_depth", 32'(bus.depth), 32'd8);
    for (int k = 0; k < DEPTH; k++) doRet(10'(32'h108 - k));
    checkOutput("wrap_depth0", 32'(bus.depth), 32'd0);
`else
    checkOutput("ovf_stall", 32'(bus.stall), 32'd1);
    applyStimulus(OP_NOP, '0);
    checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
    checkOutput("ovf_halt_stall", 32'(bus.stall), 32'd1);
    applyStimulus(OP_RET, '0);
    applyStimulus(OP_NOP, '0);
    checkOutput("ovf_halt_sret", 32'(bus.s_ret), 32'd0);
    checkOutput("ovf_halt_depth", 32'(bus.depth), 32'd8);
    checkOutput("ovf_halt_stall2", 32'(bus.stall), 32'd1);
`endif

    // Reset in the middle of a RET
    resetDut();
    applyStimulus(OP_JAL, 10'h02A);
    doRet(10'h02A);
    reset = 1'b1;
    #1;
    checkOutput("midret_sret", 32'(bus.s_ret), 32'd0);
    checkOutput("midret_ret_addr", 32'(bus.ret_addr), 32'd0);
    checkOutput("midret_depth", 32'(bus.depth), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(OP_RET, '0);
    checkOutput("midret_ret_stall", 32'(bus.stall), 32'd1);
    applyStimulus(OP_NOP, '0);
    checkOutput("midret_unf", 32'(bus.underflow), 32'd1);

    repeat (2) @(negedge clk);
    checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
